// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register-file write port.
interface regfile_wb_arbiter_if;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] pending_mask;
  logic        idle;

  modport master (
    output a_valid, a_reg, a_data,
    output b_valid, b_reg, b_data,
    input  a_ready, b_ready,
    input  wr_en, wr_reg, wr_data, pending_mask, idle
  );

  modport slave (
    input  a_valid, a_reg, a_data,
    input  b_valid, b_reg, b_data,
    output a_ready, b_ready,
    output wr_en, wr_reg, wr_data, pending_mask, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two writeback FIFOs sharing one register-file write port through a round-robin arbiter,
// with a pending-write mask for hazard detection.

module regfile_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [4:0]  push_reg,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic        not_empty,
  output logic [4:0]  head_reg,
  output logic [31:0] head_data,
  output logic [31:0] mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  // Ready looks only at occupancy, never at a same-cycle pop, and is held low in reset.
  assign ready     = rst & (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign head_reg  = reg_mem[rptr];
  assign head_data = data_mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wptr]  <= push_reg;
      data_mem[wptr] <= push_data;
    end
  end

  always_comb begin
    mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) mask[reg_mem[rptr + PW'(k)]] = 1'b1;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH   = 2,
  parameter bit DROP_R0 = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);
  typedef enum logic {LAST_A, LAST_B} last_t;

  last_t       last_grant;
  logic        a_push, b_push;
  logic        a_ne, b_ne;
  logic        a_ready_i, b_ready_i;
  logic [4:0]  a_head_reg, b_head_reg;
  logic [31:0] a_head_data, b_head_data;
  logic [31:0] a_mask, b_mask;
  logic        grant_a, grant_b;
  logic [4:0]  gnt_reg;
  logic [31:0] gnt_data;
  logic        wr_en_q;
  logic [4:0]  wr_reg_q;
  logic [31:0] wr_data_q;
  logic [31:0] mask_c;

  assign a_push = bus.a_valid & a_ready_i;
  assign b_push = bus.b_valid & b_ready_i;

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_reg  (bus.a_reg),
    .push_data (bus.a_data),
    .pop       (grant_a),
    .ready     (a_ready_i),
    .not_empty (a_ne),
    .head_reg  (a_head_reg),
    .head_data (a_head_data),
    .mask      (a_mask)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push),
    .push_reg  (bus.b_reg),
    .push_data (bus.b_data),
    .pop       (grant_b),
    .ready     (b_ready_i),
    .not_empty (b_ne),
    .head_reg  (b_head_reg),
    .head_data (b_head_data),
    .mask      (b_mask)
  );

  assign grant_a  = a_ne & (~b_ne | (last_grant == LAST_B));
  assign grant_b  = b_ne & ~grant_a;
  assign gnt_reg  = grant_a ? a_head_reg  : b_head_reg;
  assign gnt_data = grant_a ? a_head_data : b_head_data;

  // last_grant only moves on a contested cycle, so a lone requester does not steal the next tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      last_grant <= LAST_B;
    end else begin
      if (grant_a | grant_b) begin
        wr_en_q   <= !(DROP_R0 && (gnt_reg == '0));
        wr_reg_q  <= gnt_reg;
        wr_data_q <= gnt_data;
      end else begin
        wr_en_q <= 1'b0;
      end
      if (a_ne && b_ne) last_grant <= grant_a ? LAST_A : LAST_B;
    end
  end

  always_comb begin
    mask_c = a_mask | b_mask;
    if (wr_en_q) mask_c[wr_reg_q] = 1'b1;
    if (DROP_R0) mask_c[0] = 1'b0;
  end

  assign bus.a_ready      = a_ready_i;
  assign bus.b_ready      = b_ready_i;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_reg       = wr_reg_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.pending_mask = mask_c;
  assign bus.idle         = ~a_ne & ~b_ne & ~wr_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin, backpressure, r0 drop, mid-run reset.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.DEPTH(2), .DROP_R0(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
    chk({tag, ".wr_en"}, {31'b0, bus.wr_en}, {31'b0, en});
    if (en) begin
      chk({tag, ".wr_reg"}, {27'b0, bus.wr_reg}, {27'b0, r});
      chk({tag, ".wr_data"}, bus.wr_data, d);
    end
  endtask

  task automatic put_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.a_valid = v;
    bus.a_reg   = r;
    bus.a_data  = d;
  endtask

  task automatic put_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.b_valid = v;
    bus.b_reg   = r;
    bus.b_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    put_a(1'b1, 5'd9, 32'h9999_9999);
    put_b(1'b0, 5'd0, 32'h0);

    // Reset held with a_valid high
    repeat (2) tick();
    chk("rst.a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("rst.b_ready", {31'b0, bus.b_ready}, 32'd0);
    chk("rst.wr_en", {31'b0, bus.wr_en}, 32'd0);
    chk("rst.mask", bus.pending_mask, 32'h0);
    chk("rst.idle", {31'b0, bus.idle}, 32'd1);
    put_a(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel.a_ready", {31'b0, bus.a_ready}, 32'd1);
    chk("rel.idle", {31'b0, bus.idle}, 32'd1);

    // Single write
    put_a(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    put_a(1'b0, 5'd0, 32'h0);
    chk("single.mask0", bus.pending_mask, 32'h0000_0020);
    chk("single.en0", {31'b0, bus.wr_en}, 32'd0);
    chk("single.idle0", {31'b0, bus.idle}, 32'd0);
    tick();
    chk_wr("single.w1", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("single.mask1", bus.pending_mask, 32'h0000_0020);
    tick();
    chk("single.en2", {31'b0, bus.wr_en}, 32'd0);
    chk("single.hold_reg", {27'b0, bus.wr_reg}, 32'd5);
    chk("single.mask2", bus.pending_mask, 32'h0);
    chk("single.idle2", {31'b0, bus.idle}, 32'd1);

    // Tie / round-robin
    put_a(1'b1, 5'd1, 32'h11);
    put_b(1'b1, 5'd3, 32'h33);
    tick();
    put_a(1'b1, 5'd2, 32'h22);
    put_b(1'b1, 5'd4, 32'h44);
    tick();
    put_a(1'b0, 5'd0, 32'h0);
    put_b(1'b0, 5'd0, 32'h0);
    chk_wr("rr.w1", 1'b1, 5'd1, 32'h11);
    chk("rr.mask", bus.pending_mask, 32'h0000_001E);
    tick();
    chk_wr("rr.w2", 1'b1, 5'd3, 32'h33);
    tick();
    chk_wr("rr.w3", 1'b1, 5'd2, 32'h22);
    tick();
    chk_wr("rr.w4", 1'b1, 5'd4, 32'h44);
    tick();
    chk("rr.en_end", {31'b0, bus.wr_en}, 32'd0);
    chk("rr.idle", {31'b0, bus.idle}, 32'd1);

    // r0 drop
    put_a(1'b1, 5'd0, 32'h5);
    tick();
    put_a(1'b1, 5'd7, 32'h7);
    chk("r0.mask0", bus.pending_mask, 32'h0);
    chk("r0.idle0", {31'b0, bus.idle}, 32'd0);
    tick();
    put_a(1'b0, 5'd0, 32'h0);
    chk("r0.en_slot", {31'b0, bus.wr_en}, 32'd0);
    chk("r0.mask1", bus.pending_mask, 32'h0000_0080);
    tick();
    chk_wr("r0.w7", 1'b1, 5'd7, 32'h7);
    chk("r0.mask2", bus.pending_mask, 32'h0000_0080);
    tick();
    chk("r0.en_end", {31'b0, bus.wr_en}, 32'd0);
    chk("r0.mask3", bus.pending_mask, 32'h0);
    chk("r0.idle", {31'b0, bus.idle}, 32'd1);

    // Backpressure: B pushes continuously, A pushes 20,21,22
    put_a(1'b1, 5'd20, 32'hC000_0014);
    put_b(1'b1, 5'd8, 32'hC000_0008);
    chk("bp.a_ready0", {31'b0, bus.a_ready}, 32'd1);
    tick();
    chk("bp.en0", {31'b0, bus.wr_en}, 32'd0);
    put_a(1'b1, 5'd21, 32'hC000_0015);
    put_b(1'b1, 5'd9, 32'hC000_0009);
    tick();
    chk_wr("bp.w1", 1'b1, 5'd8, 32'hC000_0008);
    put_a(1'b1, 5'd22, 32'hC000_0016);
    put_b(1'b1, 5'd10, 32'hC000_000A);
    chk("bp.a_full", {31'b0, bus.a_ready}, 32'd0);
    chk("bp.b_ready2", {31'b0, bus.b_ready}, 32'd1);
    tick();
    chk_wr("bp.w2", 1'b1, 5'd20, 32'hC000_0014);
    chk("bp.mask", bus.pending_mask, 32'h0030_0600);
    put_b(1'b1, 5'd11, 32'hC000_000B);
    chk("bp.a_ready3", {31'b0, bus.a_ready}, 32'd1);
    chk("bp.b_full", {31'b0, bus.b_ready}, 32'd0);
    tick();
    chk_wr("bp.w3", 1'b1, 5'd9, 32'hC000_0009);
    put_a(1'b0, 5'd0, 32'h0);
    chk("bp.b_ready4", {31'b0, bus.b_ready}, 32'd1);
    tick();
    chk_wr("bp.w4", 1'b1, 5'd21, 32'hC000_0015);
    put_b(1'b0, 5'd0, 32'h0);
    tick();
    chk_wr("bp.w5", 1'b1, 5'd10, 32'hC000_000A);
    tick();
    chk_wr("bp.w6", 1'b1, 5'd22, 32'hC000_0016);
    tick();
    chk_wr("bp.w7", 1'b1, 5'd11, 32'hC000_000B);
    tick();
    chk("bp.en_end", {31'b0, bus.wr_en}, 32'd0);
    chk("bp.idle", {31'b0, bus.idle}, 32'd1);

    // Mid-operation reset
    put_a(1'b1, 5'd12, 32'h12);
    put_b(1'b1, 5'd13, 32'h13);
    tick();
    put_a(1'b1, 5'd14, 32'h14);
    put_b(1'b0, 5'd0, 32'h0);
    tick();
    put_a(1'b0, 5'd0, 32'h0);
    chk_wr("mrst.pre", 1'b1, 5'd13, 32'h13);
    #2 rst = 1'b0;
    #1;
    chk("mrst.en", {31'b0, bus.wr_en}, 32'd0);
    chk("mrst.reg", {27'b0, bus.wr_reg}, 32'd0);
    chk("mrst.data", bus.wr_data, 32'h0);
    chk("mrst.mask", bus.pending_mask, 32'h0);
    chk("mrst.idle", {31'b0, bus.idle}, 32'd1);
    chk("mrst.a_ready", {31'b0, bus.a_ready}, 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst.after_en", {31'b0, bus.wr_en}, 32'd0);
      chk("mrst.after_idle", {31'b0, bus.idle}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, 5-bit register number, 32-bit data) between two writeback requesters: A (ALU path) and B (load/multi-cycle path).
- Each requester has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains one entry per cycle into a registered write-port output.
- A pending-write mask is exported for hazard/stall logic.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, >=2).
- DROP_R0, 1, when 1, entries targeting register 0 are consumed but never asserted on the write port.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- a_valid  input  1  requester A has a write.
- a_ready  output  1  A FIFO can accept.
- a_reg  input  5  A destination register.
- a_data  input  32  A write data.
- b_valid  input  1  requester B has a write.
- b_ready  output  1  B FIFO can accept.
- b_reg  input  5  B destination register.
- b_data  input  32  B write data.
- wr_en  output  1  drives register-file write enable.
- wr_reg  output  5  drives register-file write register number.
- wr_data  output  32  drives register-file write data.
- pending_mask  output  32  bit i set = a write to register i is queued or on the port.
- idle  output  1  both FIFOs empty and wr_en low.

Behaviour:
- Reset (rst low, asynchronous)
  - Both FIFOs emptied.
  - wr_en=0, wr_reg=0, wr_data=0.
  - pending_mask=0, idle=1.
  - Round-robin pointer last_grant=B, so A wins the first tie.
  - a_ready=b_ready=0 while rst is low; inputs ignored.
  - Reset mid-operation discards all queued entries; no partial write is issued.
- Enqueue
  - x_ready = (count_x < DEPTH), combinational from count only; it does not depend on the same-cycle pop.
  - Push on the rising edge when x_valid && x_ready.
  - A full FIFO that pops in the same cycle still shows ready=0 that cycle.
  - x_valid while x_ready=0 is not consumed; the requester holds its data.
- Arbitration, evaluated every cycle on the FIFO heads
  - Only one head non-empty: grant it.
  - Both heads non-empty: grant the requester not equal to last_grant, then update last_grant.
  - Neither non-empty: no grant; last_grant unchanged.
  - Entries are popped in FIFO order per requester; no reordering within a requester.
  - Cross-requester order to the same register is grant order.
- Output register
  - The granted head is popped at edge k.
  - wr_en/wr_reg/wr_data are valid during cycle k..k+1, and the register file commits at edge k+1.
  - Minimum latency from accept to register-file update: 2 rising edges. Throughput: 1 write/cycle.
  - Without a grant, wr_en=0 next cycle; wr_reg/wr_data hold their last values.
  - With DROP_R0=1, a granted entry with reg=0 is popped and uses the slot, but wr_en=0.
- pending_mask
  - Combinational OR of one-hot(reg) over all valid FIFO entries in both FIFOs, plus one-hot(wr_reg) when wr_en=1.
  - Register 0 is excluded when DROP_R0=1.
  - Simultaneous push and pop are handled by the FIFO occupancy after the edge; the mask reflects current state only.
- FIFO pointers
  - log2(DEPTH)-bit pointers wrap modulo DEPTH.
  - A (log2(DEPTH)+1)-bit count disambiguates full from empty.
  - Push and pop in the same cycle leave the count unchanged.

Test Plan:
- Reset: hold rst=0 with a_valid=1 -> a_ready=0, wr_en=0, pending_mask=0, idle=1; release rst -> a_ready=1.
- Single write: A pushes reg=5, data=0xDEADBEEF at edge 0 -> wr_en=1, wr_reg=5, wr_data=0xDEADBEEF after edge 1; pending_mask bit 5 set from edge 0 until wr_en drops after edge 2.
- Tie/round-robin: A pushes (1,0x11),(2,0x22) and B pushes (3,0x33),(4,0x44) in the same two cycles -> port sequence reg 1,3,2,4 on consecutive cycles; idle=1 afterwards.
- Backpressure: DEPTH=2, hold B busy with continuous pushes while A pushes 3 entries back-to-back -> a_ready=0 after 2 accepts; the third is accepted only after an A pop; no entry lost or duplicated; order is preserved.
- r0 drop: A pushes reg=0, data=0x5 then reg=7, data=0x7 -> wr_en stays 0 for the r0 slot, then a reg-7 write with data 0x7 follows; pending_mask bit 0 is never set.
- Mid-operation reset: queue 3 entries, pulse rst low between clock edges -> outputs clear immediately; no writes appear after release.
